alu_regfile_32: RTL and testbench

//  32-bit execute datapath of the simple CPU core: a 16 x 32-bit register file (2 async read ports,
//  1 sync write port) plus a purely combinational 32-bit ALU with an 8-bit flag vector.
//  The ALU and register file have independent port groups; the core wires them together
//  (typically alu_a = data_a, alu_b = data_b or an immediate).

---
 rtl/alu_regfile_32_if.sv | 29 ++
 rtl/alu_regfile_32.sv | 178 +++++++++++++++++
 tb/tb_alu_regfile_32.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_regfile_32_if.sv
// Port bundle for the execute datapath: register-file read/write ports plus ALU operands/results.
// The core (master) drives indices, write data and ALU operands; the datapath (slave) returns data.
interface alu_regfile_32_if;
    logic [3:0]  addr_a;
    logic [31:0] data_a;
    logic [3:0]  addr_b;
    logic [31:0] data_b;
    logic [3:0]  addr_w;
    logic [31:0] data_w;
    logic        write_en;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic [7:0]  flags_in;
    logic [31:0] alu_result;
    logic [7:0]  flags_out;

    modport master (
        output addr_a, addr_b, addr_w, data_w, write_en,
        output alu_a, alu_b, alu_op, flags_in,
        input  data_a, data_b, alu_result, flags_out
    );

    modport slave (
        input  addr_a, addr_b, addr_w, data_w, write_en,
        input  alu_a, alu_b, alu_op, flags_in,
        output data_a, data_b, alu_result, flags_out
    );
endinterface

// File: rtl/alu_regfile_32.sv
// 32-bit execute datapath: 16 x 32 register file (two combinational read ports, one clocked
// write port) and an independent combinational ALU producing {flags_in[7:4], V, N, Z, C}.
module alu_regfile_32 (
    input  logic             clk,
    input  logic             rst_n,
    alu_regfile_32_if.slave  bus
);

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_ADC = 4'h2;
    localparam logic [3:0] OP_SBB = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_OR  = 4'h5;
    localparam logic [3:0] OP_XOR = 4'h6;
    localparam logic [3:0] OP_NOT = 4'h7;
    localparam logic [3:0] OP_SHL = 4'h8;
    localparam logic [3:0] OP_SHR = 4'h9;
    localparam logic [3:0] OP_SAR = 4'hA;
    localparam logic [3:0] OP_MUL = 4'hB;
    localparam logic [3:0] OP_CMP = 4'hC;
    localparam logic [3:0] OP_MOV = 4'hD;
    localparam logic [3:0] OP_INC = 4'hE;
    localparam logic [3:0] OP_DEC = 4'hF;

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [31:0] regs_q [16];

    // Register storage: async clear, then write on the rising edge when strobed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= 32'd0;
            end
        end else if (bus.write_en) begin
            regs_q[bus.addr_w] <= bus.data_w;
        end
    end

    // Reads see the stored value only; a same-cycle write shows up after the edge.
    assign bus.data_a = regs_q[bus.addr_a];
    assign bus.data_b = regs_q[bus.addr_b];

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    logic [31:0]        a_s;
    logic [31:0]        b_s;
    logic               cin_s;
    logic [4:0]         amt_s;
    logic [32:0]        sum33_s;
    logic [32:0]        diff33_s;
    logic [32:0]        shl33_s;
    logic [32:0]        shr33_s;
    logic signed [32:0] sar33_s;
    logic [31:0]        result_s;
    logic [31:0]        fsrc_s;
    logic               c_s;
    logic               v_s;
    logic               z_s;
    logic               n_s;
    logic               unused_flags_s;

    assign a_s            = bus.alu_a;
    assign b_s            = bus.alu_b;
    assign cin_s          = bus.flags_in[0];
    assign amt_s          = bus.alu_b[4:0];
    assign unused_flags_s = ^bus.flags_in[3:1];

    // Operation decode: result, carry/borrow and overflow per op; 33-bit sums expose carry/borrow.
    always_comb begin
        sum33_s  = 33'd0;
        diff33_s = 33'd0;
        shl33_s  = 33'd0;
        shr33_s  = 33'd0;
        sar33_s  = 33'sd0;
        result_s = 32'd0;
        c_s      = 1'b0;
        v_s      = 1'b0;
        case (bus.alu_op)
            OP_ADD: begin
                sum33_s  = {1'b0, a_s} + {1'b0, b_s};
                result_s = sum33_s[31:0];
                c_s      = sum33_s[32];
                v_s      = (a_s[31] == b_s[31]) && (result_s[31] != a_s[31]);
            end
            OP_ADC: begin
                sum33_s  = {1'b0, a_s} + {1'b0, b_s} + {32'd0, cin_s};
                result_s = sum33_s[31:0];
                c_s      = sum33_s[32];
                v_s      = (a_s[31] == b_s[31]) && (result_s[31] != a_s[31]);
            end
            OP_SUB, OP_CMP: begin
                diff33_s = {1'b0, a_s} - {1'b0, b_s};
                result_s = (bus.alu_op == OP_CMP) ? a_s : diff33_s[31:0];
                c_s      = diff33_s[32];
                v_s      = (a_s[31] != b_s[31]) && (diff33_s[31] != a_s[31]);
            end
            OP_SBB: begin
                // Bit 32 of the wrapped 33-bit difference is the borrow even when b + cin = 2^32.
                diff33_s = {1'b0, a_s} - {1'b0, b_s} - {32'd0, cin_s};
                result_s = diff33_s[31:0];
                c_s      = diff33_s[32];
                v_s      = (a_s[31] != b_s[31]) && (result_s[31] != a_s[31]);
            end
            OP_AND: begin
                result_s = a_s & b_s;
            end
            OP_OR: begin
                result_s = a_s | b_s;
            end
            OP_XOR: begin
                result_s = a_s ^ b_s;
            end
            OP_NOT: begin
                result_s = ~a_s;
            end
            OP_SHL: begin
                // Extra top bit catches the last bit shifted out; it stays 0 for a zero shift.
                shl33_s  = {1'b0, a_s} << amt_s;
                result_s = shl33_s[31:0];
                c_s      = shl33_s[32];
            end
            OP_SHR: begin
                // Extra bottom bit catches the last bit shifted out; it stays 0 for a zero shift.
                shr33_s  = {a_s, 1'b0} >> amt_s;
                result_s = shr33_s[32:1];
                c_s      = shr33_s[0];
            end
            OP_SAR: begin
                sar33_s  = $signed({a_s, 1'b0}) >>> amt_s;
                result_s = sar33_s[32:1];
                c_s      = sar33_s[0];
            end
            OP_MUL: begin
                result_s = a_s * b_s;
            end
            OP_MOV: begin
                result_s = b_s;
            end
            OP_INC: begin
                sum33_s  = {1'b0, a_s} + 33'd1;
                result_s = sum33_s[31:0];
                c_s      = sum33_s[32];
                v_s      = (a_s == 32'h7FFF_FFFF);
            end
            OP_DEC: begin
                diff33_s = {1'b0, a_s} - 33'd1;
                result_s = diff33_s[31:0];
                c_s      = diff33_s[32];
                v_s      = (a_s == 32'h8000_0000);
            end
            default: begin
                result_s = 32'd0;
                c_s      = 1'b0;
                v_s      = 1'b0;
            end
        endcase
    end

    // Z/N source: CMP reports on the difference it discarded, every other op on its result.
    always_comb begin
        fsrc_s = result_s;
        if (bus.alu_op == OP_CMP) begin
            fsrc_s = diff33_s[31:0];
        end else begin
            fsrc_s = result_s;
        end
        z_s = (fsrc_s == 32'd0);
        n_s = fsrc_s[31];
    end

    assign bus.alu_result = result_s;
    assign bus.flags_out  = {bus.flags_in[7:4], v_s, n_s, z_s, c_s};

endmodule

// File: tb/tb_alu_regfile_32.sv
// Scoreboard bench for alu_regfile_32: a driver issues one transaction per cycle and queues the
// expected outputs; a monitor on the falling edge pops and compares against the DUT.
module tb_alu_regfile_32;

    logic clk;
    logic rst_n;

    alu_regfile_32_if bus ();

    alu_regfile_32 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] ea;
        logic [31:0] eb;
        bit          chk_alu;
        logic [31:0] er;
        logic [7:0]  ef;
    } exp_t;

    exp_t        sb_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] model_regs [16];

    // Reference ALU from arithmetic rules on wide integers.
    function automatic void ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                    input logic [7:0] fin, output logic [31:0] res, output logic [7:0] fl);
        longint unsigned ua, ub, full;
        longint          sa, sb, sr;
        int              amt;
        logic [31:0]     fsrc;
        logic            c, v, cin;
        ua = a; ub = b; sa = $signed(a); sb = $signed(b);
        cin = fin[0]; amt = int'(b[4:0]);
        c = 1'b0; v = 1'b0; sr = 0; res = 32'd0;
        case (op)
            4'h0: begin full = ua + ub; res = a + b; c = (full >= 64'h1_0000_0000); sr = sa + sb; end
            4'h1: begin res = a - b; c = (ua < ub); sr = sa - sb; end
            4'h2: begin full = ua + ub + cin; res = full[31:0]; c = (full >= 64'h1_0000_0000);
                        sr = sa + sb + cin; end
            4'h3: begin res = a - b - {31'd0, cin}; c = (ua < ub + cin); sr = sa - sb - cin; end
            4'h4: res = a & b;
            4'h5: res = a | b;
            4'h6: res = a ^ b;
            4'h7: res = ~a;
            4'h8: begin res = a << amt; c = (amt != 0) && a[32 - amt]; end
            4'h9: begin res = a >> amt; c = (amt != 0) && a[amt - 1]; end
            4'hA: begin res = $signed(a) >>> amt; c = (amt != 0) && a[amt - 1]; end
            4'hB: begin full = ua * ub; res = full[31:0]; end
            4'hC: begin res = a; c = (ua < ub); sr = sa - sb; end
            4'hD: res = b;
            4'hE: begin full = ua + 1; res = a + 32'd1; c = (full >= 64'h1_0000_0000); sr = sa + 1; end
            default: begin res = a - 32'd1; c = (ua < 1); sr = sa - 1; end
        endcase
        if (op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'hC, 4'hE, 4'hF})
            v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        fsrc = (op == 4'hC) ? (a - b) : res;
        fl = {fin[7:4], v, fsrc[31], (fsrc == 32'd0), c};
    endfunction

    // One transaction per cycle: drive just after the rising edge, queue expectations, update model.
    task automatic drive(input string nm, input logic rstv,
                         input logic [3:0] aa, input logic [3:0] ab,
                         input logic we, input logic [3:0] aw, input logic [31:0] dw,
                         input logic [3:0] op, input logic [31:0] xa, input logic [31:0] xb,
                         input logic [7:0] fin, input bit chk_alu,
                         input logic [31:0] er, input logic [7:0] ef);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n        = rstv;
        bus.addr_a   = aa;
        bus.addr_b   = ab;
        bus.write_en = we;
        bus.addr_w   = aw;
        bus.data_w   = dw;
        bus.alu_op   = op;
        bus.alu_a    = xa;
        bus.alu_b    = xb;
        bus.flags_in = fin;
        if (!rstv) begin
            for (int i = 0; i < 16; i++) model_regs[i] = 32'd0;
        end
        e.name    = nm;
        e.ea      = model_regs[aa];
        e.eb      = model_regs[ab];
        e.chk_alu = chk_alu;
        e.er      = er;
        e.ef      = ef;
        sb_q.push_back(e);
        if (rstv && we) model_regs[aw] = dw;
    endtask

    task automatic rf(input string nm, input logic rstv, input logic [3:0] aa, input logic [3:0] ab,
                      input logic we, input logic [3:0] aw, input logic [31:0] dw);
        drive(nm, rstv, aa, ab, we, aw, dw, 4'h0, 32'd0, 32'd0, 8'h00, 1'b0, 32'd0, 8'h00);
    endtask

    // Directed ALU case with hand-derived expectations.
    task automatic alu_k(input string nm, input logic [3:0] op, input logic [31:0] xa,
                         input logic [31:0] xb, input logic [7:0] fin,
                         input logic [31:0] er, input logic [7:0] ef);
        drive(nm, 1'b1, 4'd0, 4'd0, 1'b0, 4'd0, 32'd0, op, xa, xb, fin, 1'b1, er, ef);
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] specials [6];
        specials[0] = 32'h0000_0000; specials[1] = 32'h0000_0001; specials[2] = 32'h7FFF_FFFF;
        specials[3] = 32'h8000_0000; specials[4] = 32'hFFFF_FFFF; specials[5] = 32'h0000_001F;
        if ($urandom_range(0, 2) == 0) return specials[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    // Monitor: every falling edge, compare the DUT against the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if (bus.data_a !== e.ea) begin
                failures++;
                $display("FAIL %s data_a: got %08h expected %08h", e.name, bus.data_a, e.ea);
            end
            checks++;
            if (bus.data_b !== e.eb) begin
                failures++;
                $display("FAIL %s data_b: got %08h expected %08h", e.name, bus.data_b, e.eb);
            end
            if (e.chk_alu) begin
                checks++;
                if (bus.alu_result !== e.er) begin
                    failures++;
                    $display("FAIL %s alu_result: got %08h expected %08h", e.name, bus.alu_result, e.er);
                end
                checks++;
                if (bus.flags_out !== e.ef) begin
                    failures++;
                    $display("FAIL %s flags_out: got %02h expected %02h", e.name, bus.flags_out, e.ef);
                end
            end
        end
    end

    initial begin
        logic [31:0] ra, rb, er;
        logic [7:0]  fin, ef;
        logic [3:0]  op;
        int          waited;

        rst_n = 1'b0;
        bus.addr_a = 4'd0; bus.addr_b = 4'd0; bus.addr_w = 4'd0; bus.data_w = 32'd0;
        bus.write_en = 1'b0; bus.alu_a = 32'd0; bus.alu_b = 32'd0; bus.alu_op = 4'h0;
        bus.flags_in = 8'h00;
        for (int i = 0; i < 16; i++) model_regs[i] = 32'd0;

        // Reset held: every address reads 0 and strobed writes are ignored.
        for (int i = 0; i < 16; i++) begin
            rf("reset_read", 1'b0, 4'(i), 4'(15 - i), 1'b1, 4'(i), 32'hA5A5_0000 + 32'(i));
        end
        rf("after_reset_r0", 1'b1, 4'd0, 4'd5, 1'b0, 4'd0, 32'd0);
        rf("after_reset_r15", 1'b1, 4'd15, 4'd10, 1'b0, 4'd0, 32'd0);

        // Write R3/R15, no bypass, dual-port same-register read.
        rf("wr_r3_no_bypass", 1'b1, 4'd3, 4'd3, 1'b1, 4'd3, 32'hDEAD_BEEF);
        rf("wr_r15", 1'b1, 4'd3, 4'd15, 1'b1, 4'd15, 32'h0000_0001);
        rf("rd_r3_r15", 1'b1, 4'd3, 4'd15, 1'b0, 4'd0, 32'd0);
        rf("rd_r3_r3", 1'b1, 4'd3, 4'd3, 1'b0, 4'd7, 32'h1234_5678);
        rf("wr_r0", 1'b1, 4'd0, 4'd3, 1'b1, 4'd0, 32'h0BAD_F00D);
        rf("rd_r0", 1'b1, 4'd0, 4'd7, 1'b0, 4'd0, 32'd0);

        // Directed ALU corners.
        alu_k("add_carry_zero", 4'h0, 32'hFFFF_FFFF, 32'h1, 8'h00, 32'h0, 8'h03);
        alu_k("add_overflow", 4'h0, 32'h7FFF_FFFF, 32'h1, 8'h00, 32'h8000_0000, 8'h0C);
        alu_k("sub_borrow", 4'h1, 32'd5, 32'd7, 8'h00, 32'hFFFF_FFFE, 8'h05);
        alu_k("cmp_equal", 4'hC, 32'd9, 32'd9, 8'h00, 32'd9, 8'h02);
        alu_k("adc_cin_pass", 4'h2, 32'd1, 32'd1, 8'hA1, 32'd3, 8'hA0);
        alu_k("and", 4'h4, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 8'h00, 32'h00F0_00F0, 8'h00);
        alu_k("or", 4'h5, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 8'h00, 32'hFFF0_FFF0, 8'h04);
        alu_k("xor", 4'h6, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 8'h00, 32'hFF00_FF00, 8'h04);
        alu_k("not_zero", 4'h7, 32'hFFFF_FFFF, 32'd0, 8'h00, 32'h0, 8'h02);
        alu_k("shl_carry", 4'h8, 32'h8000_0001, 32'd1, 8'h00, 32'h2, 8'h01);
        alu_k("sar_31", 4'hA, 32'h8000_0000, 32'd31, 8'h00, 32'hFFFF_FFFF, 8'h04);
        alu_k("shr_amt0", 4'h9, 32'h1234_5678, 32'h20, 8'h00, 32'h1234_5678, 8'h00);
        alu_k("mul_wrap", 4'hB, 32'h0001_0000, 32'h0001_0000, 8'h00, 32'h0, 8'h02);
        alu_k("sbb_borrow_in", 4'h3, 32'd0, 32'd0, 8'h01, 32'hFFFF_FFFF, 8'h05);
        alu_k("dec_zero", 4'hF, 32'd0, 32'd0, 8'h00, 32'hFFFF_FFFF, 8'h05);
        alu_k("inc_overflow", 4'hE, 32'h7FFF_FFFF, 32'd0, 8'h00, 32'h8000_0000, 8'h0C);
        alu_k("mov_zero", 4'hD, 32'h1234_5678, 32'd0, 8'h50, 32'h0, 8'h52);

        // Randomised mix of register-file traffic and ALU ops against the reference model.
        for (int n = 0; n < 400; n++) begin
            op  = 4'($urandom_range(0, 15));
            ra  = pick_operand();
            rb  = pick_operand();
            fin = 8'($urandom);
            ref_alu(op, ra, rb, fin, er, ef);
            drive("random", 1'b1, 4'($urandom), 4'($urandom), 1'($urandom), 4'($urandom), $urandom,
                  op, ra, rb, fin, 1'b1, er, ef);
        end

        // Mid-run reset clears populated registers immediately.
        rf("midrun_reset", 1'b0, 4'd3, 4'd15, 1'b1, 4'd3, 32'hFFFF_FFFF);
        rf("post_midrun", 1'b1, 4'd3, 4'd15, 1'b0, 4'd0, 32'd0);

        waited = 0;
        while (sb_q.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        if (sb_q.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
